eth_mdio_sched: RTL
===================

// Module: eth_mdio_sched
// PURPOSE
//  Sequencer/arbiter in front of the eth_mdio bit engine. Shares the single MDIO engine
//  between a host register-access port and an autonomous PHY status poller (BMSR, reg 1).
//  Builds 32-bit clause-22 frames, issues do_read/do_write, tracks engine busy, returns data.
//  Exports latched link status for the MAC/ethernet core.
// PARAMETERS
//  PHY_ADDR     5'd1     PHY address placed in every frame
//  POLL_CYCLES  1000000  clk cycles between poll requests; 0 = poller disabled
//  POLL_REG     5'd1     register read by the poller (BMSR)
//  LINK_BIT     2        bit of POLL_REG data reported as link_up
// PORTS
//  clk            in   1   clock
//  rstn           in   1   asynchronous active-low reset
//  cmd_valid      in   1   host command request
//  cmd_ready      out  1   host command accepted this cycle when cmd_valid&cmd_ready
//  cmd_write      in   1   1=write, 0=read
//  cmd_reg        in   5   register address
//  cmd_wdata      in   16  write data
//  rsp_valid      out  1   1-cycle pulse: host command complete
//  rsp_rdata      out  16  read data (0 for writes); valid with rsp_valid, held after
//  poll_en        in   1   enables poll timer; 0 clears timer and pending poll
//  poll_status    out  16  last POLL_REG data read
//  link_up        out  1   poll_status[LINK_BIT]
//  link_change    out  1   1-cycle pulse when link_up changes value
//  mdio_do_read   out  1   to engine do_read (1-cycle pulse)
//  mdio_do_write  out  1   to engine do_write (1-cycle pulse)
//  mdio_txdata    out  32  to engine txdata; held stable from issue until frame completes
//  mdio_rxdata    in   16  from engine rxdata
//  mdio_busy      in   1   from engine busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timer 0, poll_pend 0, last_grant=POLL.
//  Frames (MSB first): read  {2'b01,2'b10,PHY_ADDR,reg,2'b11,16'hFFFF}
//                      write {2'b01,2'b01,PHY_ADDR,reg,2'b10,wdata}; preamble 32'hFFFFFFFF.
//  Timer: when poll_en & POLL_CYCLES!=0, counts 0..POLL_CYCLES-1, wraps, sets poll_pend at
//   wrap; poll_pend already set stays set (no queue depth). Timer runs during transactions.
//  Arbitration in IDLE only when mdio_busy==0; round-robin on last_grant when both pending;
//   cmd_ready = IDLE & !mdio_busy & !(poll_pend & last_grant==HOST). Grant clears poll_pend.
//  FSM: IDLE -> [PRE_GO -> PRE_HI -> PRE_LO] -> GO -> WAIT_HI -> WAIT_LO -> IDLE.
//   GO/PRE_GO: assert do_read or do_write for exactly 1 cycle (preamble uses do_write).
//   *_HI: wait for mdio_busy=1. *_LO: wait for mdio_busy=0; in WAIT_LO on busy fall capture
//   mdio_rxdata: host -> rsp_rdata + rsp_valid pulse next cycle; poll -> poll_status,
//   link_change if bit changed. Issue latency: accept cycle -> do_* next cycle.
//  Back-to-back: a new grant is possible the cycle after returning to IDLE.
//  cmd fields sampled only at acceptance; later changes ignored.
//  poll_en falling mid-poll: in-flight poll completes and updates status normally.
//  Reset mid-frame: FSM returns to IDLE; engine (unreset) finishes its frame; arbitration
//   gated by mdio_busy==0 so no do_* issues until engine idle. Outputs cleared immediately.
// CONFIGURATION
//  MDIO_PREAMBLE_EN defined: every transaction preceded by one all-ones preamble frame
//   (PRE_GO/PRE_HI/PRE_LO states). Not defined: preamble states absent, GO follows grant
//   directly (PHY must support preamble suppression).
// TESTING (bench uses eth_mdio + PHY model, small CLKDIV, POLL_CYCLES=200)
//  Host write reg0 0x1200 -> mdio_txdata=0x50821200, one do_write pulse, rsp_valid once, rdata=0.
//  Host read reg1, PHY returns 0x786D -> txdata=0x6087FFFF, do_read pulse, rsp_rdata=0x786D.
//  Poll with PHY BMSR 0x7869 then 0x786D -> link_up 0->1, link_change one pulse, status 0x786D.
//  cmd_valid held while poll_pend -> grants alternate poll/host/poll; no do_* while busy.
//  Assert rstn low mid-frame -> outputs 0 at once; first do_* only after mdio_busy falls.
//  With MDIO_PREAMBLE_EN -> 0xFFFFFFFF write frame precedes each command frame; without -> none.

Source files
------------

// File: rtl/eth_mdio_sched_if.sv
// -----------------------------------------------------------------------------
// eth_mdio_sched_if
//   Host register-access bus between a register client and eth_mdio_sched.
//   Signals:
//     cmd_valid  host -> sched  command request
//     cmd_ready  sched -> host  command accepted when cmd_valid & cmd_ready
//     cmd_write  host -> sched  1 = write, 0 = read
//     cmd_reg    host -> sched  5-bit clause-22 register address
//     cmd_wdata  host -> sched  16-bit write data
//     rsp_valid  sched -> host  1-cycle completion pulse
//     rsp_rdata  sched -> host  read data (0 for writes), held after rsp_valid
//   Modports: master = host side, slave = scheduler side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface eth_mdio_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/eth_mdio_sched.sv
// -----------------------------------------------------------------------------
// eth_mdio_sched
//   Sequencer/arbiter in front of the eth_mdio bit engine. Shares the engine
//   between a host register port and an autonomous PHY status poller, builds
//   32-bit clause-22 frames, issues do_read/do_write, tracks engine busy and
//   returns data. Exports the latched link status for the MAC.
//
//   Optional build macro: MDIO_PREAMBLE_EN
//     defined   -> every transaction is preceded by one all-ones preamble frame
//     undefined -> command frame issued directly after the grant
//
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset
//     host           eth_mdio_sched_if.slave (cmd_*/rsp_* handshake)
//     poll_en        enables poll timer; low clears timer and pending poll
//     poll_status    last POLL_REG data read by the poller
//     link_up        poll_status[LINK_BIT]
//     link_change    1-cycle pulse when link_up changes
//     mdio_do_read   engine read strobe (1 cycle)
//     mdio_do_write  engine write strobe (1 cycle)
//     mdio_txdata    engine frame, stable from issue until the frame completes
//     mdio_rxdata    engine read data
//     mdio_busy      engine busy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module eth_mdio_sched #(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         POLL_CYCLES = 1000000,
  parameter logic [4:0] POLL_REG    = 5'd1,
  parameter int         LINK_BIT    = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  eth_mdio_sched_if.slave        host,
  input  logic                   poll_en,
  output logic [15:0]            poll_status,
  output logic                   link_up,
  output logic                   link_change,
  output logic                   mdio_do_read,
  output logic                   mdio_do_write,
  output logic [31:0]            mdio_txdata,
  input  logic [15:0]            mdio_rxdata,
  input  logic                   mdio_busy
);

  localparam int            TW         = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
  localparam bit            POLL_ON    = (POLL_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GO      = 3'd1,
    ST_WAIT_HI = 3'd2,
`ifdef MDIO_PREAMBLE_EN
    ST_WAIT_LO = 3'd3,
    ST_PRE_GO  = 3'd4,
    ST_PRE_HI  = 3'd5,
    ST_PRE_LO  = 3'd6
`else
    ST_WAIT_LO = 3'd3
`endif
  } state_t;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_POLL = 1'b1
  } grant_t;

  // Clause-22 frame, MSB first: ST, OP, PHYAD, REGAD, TA, DATA.
  function automatic logic [31:0] build_frame(input logic wr, input logic [4:0] ra,
                                              input logic [15:0] wd);
    if (wr) begin
      build_frame = {2'b01, 2'b01, PHY_ADDR, ra, 2'b10, wd};
    end else begin
      build_frame = {2'b01, 2'b10, PHY_ADDR, ra, 2'b11, 16'hFFFF};
    end
  endfunction

  state_t        state_r;
  state_t        state_nx_s;
  grant_t        last_grant_r;
  logic          rst_done_r;
  logic          cur_poll_r;
  logic          cur_write_r;
  logic          do_read_r;
  logic          do_write_r;
  logic [31:0]   txdata_r;
  logic          rsp_valid_r;
  logic [15:0]   rsp_rdata_r;
  logic [15:0]   poll_status_r;
  logic          link_change_r;
  logic [TW-1:0] timer_r;
  logic          poll_pend_r;
`ifdef MDIO_PREAMBLE_EN
  logic [31:0]   cmd_frame_r;
  logic          frame_go_s;
`endif

  logic          arb_ok_s;
  logic          ready_s;
  logic          grant_host_s;
  logic          grant_poll_s;
  logic [31:0]   frame_sel_s;
  logic          issue_rd_s;
  logic          issue_wr_s;
  logic          done_s;

  // Arbitration only while idle with the engine quiet. When the poller is
  // pending and the host had the last grant, the host is held off so the
  // two sources alternate. rst_done_r keeps cmd_ready low while in reset.
  assign arb_ok_s     = rst_done_r && (state_r == ST_IDLE) && !mdio_busy;
  assign ready_s      = arb_ok_s && !(poll_pend_r && (last_grant_r == GRANT_HOST));
  assign grant_host_s = ready_s && host.cmd_valid;
  assign grant_poll_s = arb_ok_s && poll_pend_r &&
                        ((last_grant_r == GRANT_HOST) || !host.cmd_valid);
  assign frame_sel_s  = grant_poll_s ? build_frame(1'b0, POLL_REG, 16'h0000)
                                     : build_frame(host.cmd_write, host.cmd_reg, host.cmd_wdata);

  assign host.cmd_ready = ready_s;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_rdata = rsp_rdata_r;
  assign poll_status    = poll_status_r;
  assign link_up        = poll_status_r[LINK_BIT];
  assign link_change    = link_change_r;
  assign mdio_do_read   = do_read_r;
  assign mdio_do_write  = do_write_r;
  assign mdio_txdata    = txdata_r;

  // Next-state logic; issue_* select the engine strobe for the next cycle.
  always_comb begin
    state_nx_s = state_r;
    issue_rd_s = 1'b0;
    issue_wr_s = 1'b0;
    done_s     = 1'b0;
`ifdef MDIO_PREAMBLE_EN
    frame_go_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (grant_host_s || grant_poll_s) begin
`ifdef MDIO_PREAMBLE_EN
          state_nx_s = ST_PRE_GO;
          issue_wr_s = 1'b1;
`else
          state_nx_s = ST_GO;
          if (grant_host_s && host.cmd_write) begin
            issue_wr_s = 1'b1;
          end else begin
            issue_rd_s = 1'b1;
          end
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
`ifdef MDIO_PREAMBLE_EN
      ST_PRE_GO: state_nx_s = ST_PRE_HI;
      ST_PRE_HI: begin
        if (mdio_busy) begin
          state_nx_s = ST_PRE_LO;
        end else begin
          state_nx_s = ST_PRE_HI;
        end
      end
      ST_PRE_LO: begin
        if (!mdio_busy) begin
          state_nx_s = ST_GO;
          frame_go_s = 1'b1;
          if (cur_write_r) begin
            issue_wr_s = 1'b1;
          end else begin
            issue_rd_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_PRE_LO;
        end
      end
`endif
      ST_GO: state_nx_s = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (mdio_busy) begin
          state_nx_s = ST_WAIT_LO;
        end else begin
          state_nx_s = ST_WAIT_HI;
        end
      end
      ST_WAIT_LO: begin
        if (!mdio_busy) begin
          state_nx_s = ST_IDLE;
          done_s     = 1'b1;
        end else begin
          state_nx_s = ST_WAIT_LO;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register, engine strobes, grant bookkeeping and the frame register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      rst_done_r   <= 1'b0;
      last_grant_r <= GRANT_POLL;
      cur_poll_r   <= 1'b0;
      cur_write_r  <= 1'b0;
      do_read_r    <= 1'b0;
      do_write_r   <= 1'b0;
      txdata_r     <= 32'h0000_0000;
`ifdef MDIO_PREAMBLE_EN
      cmd_frame_r  <= 32'h0000_0000;
`endif
    end else begin
      state_r    <= state_nx_s;
      rst_done_r <= 1'b1;
      do_read_r  <= issue_rd_s;
      do_write_r <= issue_wr_s;
      if (grant_host_s || grant_poll_s) begin
        last_grant_r <= grant_poll_s ? GRANT_POLL : GRANT_HOST;
        cur_poll_r   <= grant_poll_s;
        cur_write_r  <= grant_host_s && host.cmd_write;
`ifdef MDIO_PREAMBLE_EN
        txdata_r     <= 32'hFFFF_FFFF;
        cmd_frame_r  <= frame_sel_s;
`else
        txdata_r     <= frame_sel_s;
`endif
      end
`ifdef MDIO_PREAMBLE_EN
      else if (frame_go_s) begin
        txdata_r <= cmd_frame_r;
      end
`endif
      else begin
        txdata_r <= txdata_r;
      end
    end
  end

  // Completion: host response pulse or poll status / link change update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 16'h0000;
      poll_status_r <= 16'h0000;
      link_change_r <= 1'b0;
    end else begin
      rsp_valid_r   <= 1'b0;
      link_change_r <= 1'b0;
      if (done_s) begin
        if (cur_poll_r) begin
          poll_status_r <= mdio_rxdata;
          link_change_r <= mdio_rxdata[LINK_BIT] ^ poll_status_r[LINK_BIT];
        end else begin
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= cur_write_r ? 16'h0000 : mdio_rxdata;
        end
      end
    end
  end

  // Poll interval timer; keeps running during transactions. The pending flag
  // is one deep: a wrap while already pending is absorbed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_r     <= {TW{1'b0}};
      poll_pend_r <= 1'b0;
    end else if (!poll_en || !POLL_ON) begin
      timer_r     <= {TW{1'b0}};
      poll_pend_r <= 1'b0;
    end else if (timer_r == TIMER_LAST) begin
      timer_r     <= {TW{1'b0}};
      poll_pend_r <= 1'b1;
    end else begin
      timer_r     <= timer_r + TW'(1);
      poll_pend_r <= grant_poll_s ? 1'b0 : poll_pend_r;
    end
  end

endmodule
